// File: rtl/gpio_cfg_shifter_if.sv
// Signal bundle between the pad-config shifter, its register file and the GPIO control chain.
// The master modport is the shifter side; slave is the register-file / chain side.
interface gpio_cfg_shifter_if #(
  parameter int CFG_BITS = 13
);
  logic                start;
  logic [CFG_BITS-1:0] cfg_word;
  logic [5:0]          cfg_idx;
  logic                busy;
  logic                done;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;

  modport master (
    input  start, cfg_word,
    output cfg_idx, busy, done, serial_clock, serial_data, serial_load
  );

  modport slave (
    output start, cfg_word,
    input  cfg_idx, busy, done, serial_clock, serial_data, serial_load
  );
endinterface

// File: rtl/gpio_cfg_shifter.sv
// Serialises NPADS pad configuration words (highest pad first, MSB first) into the GPIO control chain.
// Optional macro GPIO_CFG_SHIFTER_LOAD_CNT_EN adds a saturating count of completed transfers (load_count).
module gpio_cfg_shifter #(
  parameter int NPADS    = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  gpio_cfg_shifter_if.master bus
`ifdef GPIO_CFG_SHIFTER_LOAD_CNT_EN
  ,
  output logic [7:0]         load_count
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LOAD, DONE} state_t;

  localparam logic [5:0] LAST_PAD  = 6'(NPADS - 1);
  localparam logic [4:0] LAST_BIT  = 5'(CFG_BITS - 1);
  localparam logic [8:0] SLOT_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] HALF      = 9'(CLK_DIV);
  localparam logic [8:0] LOAD_LAST = 9'(CLK_DIV - 1);

  state_t              state, state_nxt;
  logic [5:0]          cfg_idx, cfg_idx_nxt;
  logic [8:0]          div_cnt, div_cnt_nxt;
  logic [4:0]          bit_cnt, bit_cnt_nxt;
  logic [CFG_BITS-1:0] shreg, shreg_nxt;
  logic                data_q;
  logic                busy, done, sclk, sdata, sload;

  // data_q remembers the last driven serial_data so FETCH can hold it between words
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cfg_idx <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_idx <= cfg_idx_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      data_q  <= sdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    cfg_idx_nxt = cfg_idx;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    busy        = 1'b0;
    done        = 1'b0;
    sclk        = 1'b0;
    sdata       = 1'b0;
    sload       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt   = FETCH;
          cfg_idx_nxt = LAST_PAD;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end
      FETCH: begin
        busy        = 1'b1;
        sdata       = data_q;
        shreg_nxt   = bus.cfg_word;
        div_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        state_nxt   = SHIFT;
      end
      // one bit slot: CLK_DIV cycles low then CLK_DIV high, data held for the whole slot
      SHIFT: begin
        busy  = 1'b1;
        sclk  = (div_cnt >= HALF);
        sdata = shreg[CFG_BITS-1];
        if (div_cnt == SLOT_LAST) begin
          div_cnt_nxt = '0;
          shreg_nxt   = shreg << 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            if (cfg_idx == 6'd0) begin
              state_nxt = LOAD;
            end else begin
              state_nxt   = FETCH;
              cfg_idx_nxt = cfg_idx - 6'd1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt + 9'd1;
        end
      end
      LOAD: begin
        busy  = 1'b1;
        sload = 1'b1;
        if (div_cnt == LOAD_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = DONE;
        end else begin
          div_cnt_nxt = div_cnt + 9'd1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cfg_idx      = cfg_idx;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.serial_clock = sclk;
  assign bus.serial_data  = sdata;
  assign bus.serial_load  = sload;

`ifdef GPIO_CFG_SHIFTER_LOAD_CNT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      load_count <= '0;
    end else if (state == DONE && load_count != 8'hFF) begin
      load_count <= load_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/gpio_cfg_shifter.md
GPIO_CFG_SHIFTER -- requirements
Module: gpio_cfg_shifter

Interface
REQ-001 Parameter NPADS, default 38: number of pad configuration words per transfer; range 1..64.
REQ-002 Parameter CFG_BITS, default 13: bits per pad configuration word; range 1..16.
REQ-003 Parameter CLK_DIV, default 2: serial clock half-period in wb_clk_i cycles; range 1..255.
REQ-004 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  transfer request; sampled only in IDLE.
REQ-007 cfg_word  input  CFG_BITS  configuration word for the pad addressed by cfg_idx; driven by the register file.
REQ-008 cfg_idx  output  6  pad index currently requested.
REQ-009 busy  output  1  high while a transfer is in progress.
REQ-010 done  output  1  one-cycle pulse when a transfer completes.
REQ-011 serial_clock  output  1  shift clock to the GPIO control chain.
REQ-012 serial_data  output  1  shift data to the chain.
REQ-013 serial_load  output  1  latch strobe to the chain.

Function
REQ-014 States: IDLE, FETCH, SHIFT, LOAD, DONE.
- IDLE->FETCH: start=1.
- FETCH->SHIFT: after 1 cycle.
- SHIFT->FETCH: last bit of word, cfg_idx>0.
- SHIFT->LOAD: last bit of word 0.
- LOAD->DONE: after CLK_DIV cycles.
- DONE->IDLE: after 1 cycle.
REQ-015 On IDLE->FETCH: cfg_idx<=NPADS-1 and busy<=1.
- Words are sent in order pad NPADS-1 down to pad 0.
- On each subsequent FETCH entry, cfg_idx decrements by 1.
REQ-016 FETCH:
- cfg_word is captured into an internal shift register at the end of the cycle.
- serial_clock=0; serial_data holds its previous value.
REQ-017 SHIFT bit slots:
- Each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles with serial_clock=0, then CLK_DIV cycles with serial_clock=1.
- serial_data carries the current bit, MSB first, and is stable for the whole slot.
REQ-018 LOAD:
- serial_load=1 for exactly CLK_DIV cycles.
- serial_clock=0; serial_data=0.
REQ-019 DONE:
- done=1 and busy=0 for one cycle.
- No other cycle has done=1.
REQ-020 busy is high for exactly NPADS*(1+2*CFG_BITS*CLK_DIV)+CLK_DIV cycles per transfer.
REQ-021 start is ignored in FETCH, SHIFT, LOAD and DONE; it is not queued.
REQ-022 If start is held high, a new transfer begins on the cycle after DONE.
REQ-023 Bit and divider counters wrap to their reload values at each slot and word boundary, with no idle cycle inserted between bit slots.

Reset
REQ-024 wb_rst_i=1 at any edge, including mid-transfer, forces on that edge:
- state IDLE, cfg_idx=0, busy=0, done=0;
- serial_clock=0, serial_data=0, serial_load=0;
- all counters 0.
REQ-025 An aborted transfer produces no serial_load pulse; the first start after reset release begins a full new transfer.

Configuration
REQ-026 Macro GPIO_CFG_SHIFTER_LOAD_CNT_EN.
- Defined: adds output load_count (8 bits), reset to 0, incremented on each DONE cycle, saturating at 255.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-027 NPADS=2, CFG_BITS=3, CLK_DIV=1; cfg_word=3'b101 for idx 1 and 3'b011 for idx 0; pulse start ->
- serial_data sampled on serial_clock rising edges reads 1,0,1,0,1,1;
- busy is high for 15 cycles, then done pulses once.
REQ-028 Same configuration, CLK_DIV=3 ->
- serial_clock is 3 cycles low and 3 cycles high per bit;
- serial_load is high 3 cycles;
- busy is high for 2*(1+18)+3=41 cycles.
REQ-029 start pulsed again while busy=1, and once more during the DONE cycle -> exactly one transfer and one done pulse.
REQ-030 wb_rst_i asserted for one cycle in the middle of SHIFT of word 1 ->
- all outputs are 0 on the next cycle;
- no serial_load occurs;
- the next start gives the full REQ-027 sequence.
REQ-031 start held high continuously for 40 cycles with the REQ-027 configuration -> two complete back-to-back transfers, with done at cycle 16 and cycle 33 counting from the first start edge.
REQ-032 With GPIO_CFG_SHIFTER_LOAD_CNT_EN, 257 transfers -> load_count reads 255; a reset then makes it read 0.
